// File: rtl/rm_buff_sequencer.sv
// Rate-matching circular buffer sequencer: drains three interleaver RAMs into the buffer, then runs bit selection.
// Optional macro RM_NULL_SKIP_EN enables dummy-entry skipping and the all-null guard.
module rm_buff_sequencer #(
    parameter int AW = 13,
    parameter int KW = 12,
    parameter int EW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] K_PI,
    input  logic [AW-1:0] Ko,
    input  logic [EW-1:0] E,
    input  logic          src_valid,
    output logic          readRAM1,
    output logic          readRAM2,
    output logic          readRAM3,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic          null_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR1,
        S_WR2,
        S_WR3,
        S_SEL,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [KW-1:0] k_pi_q;
    logic [EW-1:0] e_q;
    logic [AW:0]   ncb_q;
    logic [KW-1:0] idx;
    logic [AW-1:0] addr;
    logic [EW-1:0] out_cnt;
    logic          rd_pend;
    logic          hold;
    logic          err_q;

    logic [AW:0]   cfg_ncb;
    logic          cfg_bad;
    logic          last_wr;
    logic          ret_valid;
    logic          out_valid_int;
    logic          accept;
    logic          out_last_int;
    logic          final_accept;
    logic [EW:0]   committed;
    logic          issue;
    logic [AW:0]   addr_inc;
    logic [AW-1:0] addr_next;

    assign cfg_ncb = {1'b0, K_PI} + ({1'b0, K_PI} << 1);
    assign cfg_bad = (K_PI == '0) || (E == '0) || ({1'b0, Ko} >= cfg_ncb);
    assign last_wr = src_valid && (idx == k_pi_q - 1'b1);

`ifdef RM_NULL_SKIP_EN
    logic [AW:0] null_run;
    logic        null_hit;
    logic        all_null;

    assign null_hit  = (state == S_SEL) && rd_pend && null_flag;
    assign all_null  = null_hit && ((null_run + 1'b1) == ncb_q);
    assign ret_valid = rd_pend && !null_flag;
`else
    logic unused_null;

    assign unused_null = null_flag;
    assign ret_valid   = rd_pend;
`endif

    // The returning entry is presented in the cycle it arrives; only a refused one is parked in hold.
    assign out_valid_int = (state == S_SEL) && (hold || ret_valid);
    assign accept        = out_valid_int && out_ready;
    assign out_last_int  = out_valid_int && (out_cnt == e_q - 1'b1);
    assign final_accept  = accept && out_last_int;
    assign committed     = {1'b0, out_cnt} + {{EW{1'b0}}, out_valid_int};

`ifdef RM_NULL_SKIP_EN
    assign issue = (state == S_SEL) && (!out_valid_int || out_ready) &&
                   (committed < {1'b0, e_q}) && !all_null;
`else
    assign issue = (state == S_SEL) && (!out_valid_int || out_ready) &&
                   (committed < {1'b0, e_q});
`endif

    assign addr_inc  = {1'b0, addr} + 1'b1;
    assign addr_next = (addr_inc == ncb_q) ? '0 : addr_inc[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        readRAM1   = 1'b0;
        readRAM2   = 1'b0;
        readRAM3   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = cfg_bad ? S_DONE : S_WR1;
                end
            end
            S_WR1: begin
                readRAM1 = 1'b1;
                wr_en    = src_valid;
                wr_addr  = AW'(idx);
                if (last_wr) begin
                    next_state = S_WR2;
                end
            end
            S_WR2: begin
                readRAM2 = 1'b1;
                wr_en    = src_valid;
                wr_addr  = AW'(k_pi_q) + (AW'(idx) << 1);
                if (last_wr) begin
                    next_state = S_WR3;
                end
            end
            S_WR3: begin
                readRAM3 = 1'b1;
                wr_en    = src_valid;
                wr_addr  = AW'(k_pi_q) + (AW'(idx) << 1) + AW'(1);
                if (last_wr) begin
                    next_state = S_SEL;
                end
            end
            S_SEL: begin
                rd_en   = issue;
                rd_addr = addr;
                if (final_accept) begin
                    next_state = S_DONE;
                end
`ifdef RM_NULL_SKIP_EN
                if (all_null) begin
                    next_state = S_DONE;
                end
`endif
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_pi_q   <= '0;
            e_q      <= '0;
            ncb_q    <= '0;
            idx      <= '0;
            addr     <= '0;
            out_cnt  <= '0;
            rd_pend  <= 1'b0;
            hold     <= 1'b0;
            err_q    <= 1'b0;
`ifdef RM_NULL_SKIP_EN
            null_run <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_pi_q   <= K_PI;
                        e_q      <= E;
                        ncb_q    <= cfg_ncb;
                        addr     <= Ko;
                        idx      <= '0;
                        out_cnt  <= '0;
                        rd_pend  <= 1'b0;
                        hold     <= 1'b0;
                        err_q    <= cfg_bad;
`ifdef RM_NULL_SKIP_EN
                        null_run <= '0;
`endif
                    end
                end
                S_WR1, S_WR2, S_WR3: begin
                    if (src_valid) begin
                        idx <= last_wr ? '0 : idx + 1'b1;
                    end
                end
                S_SEL: begin
                    rd_pend <= issue;
                    hold    <= out_valid_int && !out_ready;
                    if (issue) begin
                        addr <= addr_next;
                    end
                    if (accept) begin
                        out_cnt <= out_cnt + 1'b1;
                    end
`ifdef RM_NULL_SKIP_EN
                    if (null_hit) begin
                        null_run <= null_run + 1'b1;
                    end else if (rd_pend) begin
                        null_run <= '0;
                    end
                    if (all_null) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    rd_pend <= 1'b0;
                    hold    <= 1'b0;
                end
                default: begin
                    rd_pend <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_int;
    assign out_last  = out_last_int;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_rm_buff_sequencer.sv
// Scoreboard bench for rm_buff_sequencer: expected write/read/output addresses are queued per operation
// and popped as the DUT produces them; scenario tasks check timing, stalls, gaps, nulls and errors.
module tb_rm_buff_sequencer;

    localparam int AW = 13;
    localparam int KW = 12;
    localparam int EW = 16;
`ifdef RM_NULL_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] K_PI;
    logic [AW-1:0] Ko;
    logic [EW-1:0] E;
    logic          src_valid;
    logic          readRAM1;
    logic          readRAM2;
    logic          readRAM3;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          null_flag;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    rm_buff_sequencer #(.AW(AW), .KW(KW), .EW(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .K_PI(K_PI), .Ko(Ko), .E(E),
        .src_valid(src_valid), .readRAM1(readRAM1), .readRAM2(readRAM2), .readRAM3(readRAM3),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .null_flag(null_flag), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit null_map [0:63];
    int exp_wr[$];
    int exp_rd[$];
    int exp_out[$];
    int src_mode, stall_at, abort_wr;
    int n_wr, n_out, last_count, last_idx, last_cyc, done_cyc;
    bit err_at_done, busy_at_done, aborted;
    int stall_cnt, stall_bad_valid, stall_bad_rd;
    int gap_cnt, gap_bad_wren, gap_addr_bad;
    int null_cycles, null_valid_hi;

    // Reference model: write order of the three drains and the wrapped, null-skipping read order.
    task automatic build_expect(input int k, input int ko, input int e);
        int ncb, a, outs, run;
        exp_wr.delete();
        exp_rd.delete();
        exp_out.delete();
        ncb = 3 * k;
        if (k == 0 || e == 0 || ko >= ncb) return;
        for (int i = 0; i < k; i++) exp_wr.push_back(i);
        for (int i = 0; i < k; i++) exp_wr.push_back(k + 2 * i);
        for (int i = 0; i < k; i++) exp_wr.push_back(k + 2 * i + 1);
        a = ko;
        outs = 0;
        run = 0;
        while (outs < e) begin
            exp_rd.push_back(a);
            if (SKIP && null_map[a]) begin
                run++;
                if (run == ncb) break;
            end else begin
                exp_out.push_back(a);
                outs++;
                run = 0;
            end
            a = (a + 1 == ncb) ? 0 : a + 1;
        end
    endtask

    task automatic run_op(input int k, input int ko, input int e);
        int want, present, held_addr, prev_rd_addr, gap_addr;
        bit prev_rd_en, gap_pend;
        n_wr = 0; n_out = 0; last_count = 0; last_idx = -1; last_cyc = -1; done_cyc = -1;
        err_at_done = 1'b0; busy_at_done = 1'b1; aborted = 1'b0;
        stall_cnt = 0; stall_bad_valid = 0; stall_bad_rd = 0;
        gap_cnt = 0; gap_bad_wren = 0; gap_addr_bad = 0;
        null_cycles = 0; null_valid_hi = 0;
        held_addr = -1; prev_rd_addr = 0; prev_rd_en = 1'b0; gap_pend = 1'b0; gap_addr = 0;
        @(posedge clk);
        #1;
        K_PI = KW'(k); Ko = AW'(ko); E = EW'(e);
        start = 1'b1; src_valid = 1'b0; null_flag = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                null_flag = prev_rd_en ? null_map[prev_rd_addr] : 1'b0;
                src_valid = (src_mode == 1 && n_wr >= k && n_wr < 2 * k) ? (cyc % 2 == 0) : 1'b1;
                out_ready = !(stall_at >= 0 && n_out == stall_at && stall_cnt < 3);
            end
            @(negedge clk);
            if (!out_ready) begin
                stall_cnt++;
                if (!out_valid) stall_bad_valid++;
                if (rd_en) stall_bad_rd++;
            end
            if (wr_en) begin
                if (gap_pend && int'(wr_addr) != gap_addr) gap_addr_bad++;
                gap_pend = 1'b0;
                want = -1;
                if (exp_wr.size() > 0) want = exp_wr.pop_front();
                n_vec++;
                if (int'(wr_addr) !== want) begin
                    n_err++;
                    $display("[TB] FAIL wr_addr[%0d]: got %0d expected %0d", n_wr, wr_addr, want);
                end
                n_wr++;
            end
            if (readRAM2 && !src_valid) begin
                gap_cnt++;
                if (wr_en) gap_bad_wren++;
                gap_addr = int'(wr_addr);
                gap_pend = 1'b1;
            end
            if (prev_rd_en && null_map[prev_rd_addr]) begin
                null_cycles++;
                if (out_valid) null_valid_hi++;
            end
            if (out_valid) begin
                present = prev_rd_en ? prev_rd_addr : held_addr;
                if (out_ready) begin
                    want = -1;
                    if (exp_out.size() > 0) want = exp_out.pop_front();
                    n_vec++;
                    if (present !== want) begin
                        n_err++;
                        $display("[TB] FAIL out_addr[%0d]: got %0d expected %0d", n_out, present, want);
                    end
                    if (out_last) begin
                        last_count++;
                        last_idx = n_out;
                        last_cyc = cyc;
                    end
                    n_out++;
                end else begin
                    held_addr = present;
                end
            end
            if (rd_en) begin
                want = -1;
                if (exp_rd.size() > 0) want = exp_rd.pop_front();
                n_vec++;
                if (int'(rd_addr) !== want) begin
                    n_err++;
                    $display("[TB] FAIL rd_addr: got %0d expected %0d", rd_addr, want);
                end
            end
            prev_rd_en = rd_en;
            prev_rd_addr = int'(rd_addr);
            if (abort_wr >= 0 && n_wr == abort_wr) begin
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (done) begin
                done_cyc = cyc;
                err_at_done = err;
                busy_at_done = busy;
                break;
            end
        end
        start = 1'b0; src_valid = 1'b0; null_flag = 1'b0; out_ready = 1'b1;
        if (!aborted) begin
            n_vec++;
            if (done_cyc < 0) begin
                n_err++;
                $display("[TB] FAIL done_timeout: got no done expected done within 300 cycles");
            end
            n_vec++;
            if (exp_wr.size() + exp_rd.size() + exp_out.size() != 0) begin
                n_err++;
                $display("[TB] FAIL missing_events: got %0d/%0d/%0d left expected 0/0/0",
                         exp_wr.size(), exp_rd.size(), exp_out.size());
            end
        end
        exp_wr.delete();
        exp_rd.delete();
        exp_out.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_vec++;
        if ({readRAM1, readRAM2, readRAM3, wr_en, wr_addr, rd_en, rd_addr,
             out_valid, out_last, busy, done, err} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got nonzero expected all zero");
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_full_pass();
        build_expect(4, 0, 12);
        run_op(4, 0, 12);
        n_vec++;
        if (last_count !== 1 || last_idx !== 11) begin
            n_err++;
            $display("[TB] FAIL full_last: got count %0d idx %0d expected 1 11", last_count, last_idx);
        end
        n_vec++;
        if (done_cyc !== last_cyc + 1) begin
            n_err++;
            $display("[TB] FAIL full_done_timing: got %0d expected %0d", done_cyc, last_cyc + 1);
        end
        n_vec++;
        if (err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL full_flags: got err %0d busy %0d expected 0 0", err_at_done, busy_at_done);
        end
    endtask

    task automatic test_wrap();
        build_expect(4, 10, 5);
        run_op(4, 10, 5);
        n_vec++;
        if (last_count !== 1 || last_idx !== 4) begin
            n_err++;
            $display("[TB] FAIL wrap_last: got count %0d idx %0d expected 1 4", last_count, last_idx);
        end
        build_expect(2, 3, 10);
        run_op(2, 3, 10);
        n_vec++;
        if (n_out !== 10 || err_at_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wrap_long: got outs %0d err %0d expected 10 0", n_out, err_at_done);
        end
    endtask

    task automatic test_src_gaps();
        src_mode = 1;
        build_expect(4, 0, 2);
        run_op(4, 0, 2);
        src_mode = 0;
        n_vec++;
        if (gap_cnt < 3 || gap_bad_wren !== 0 || gap_addr_bad !== 0) begin
            n_err++;
            $display("[TB] FAIL src_gaps: got gaps %0d wren %0d addr_bad %0d expected >=3 0 0",
                     gap_cnt, gap_bad_wren, gap_addr_bad);
        end
        n_vec++;
        if (n_wr !== 12) begin
            n_err++;
            $display("[TB] FAIL gap_writes: got %0d expected 12", n_wr);
        end
    endtask

    task automatic test_null();
        null_map[1] = 1'b1;
        null_map[2] = 1'b1;
        build_expect(4, 0, 4);
        run_op(4, 0, 4);
        n_vec++;
        if (null_cycles !== 2 || null_valid_hi !== (SKIP ? 0 : 2)) begin
            n_err++;
            $display("[TB] FAIL null_valid: got cycles %0d valid %0d expected 2 %0d",
                     null_cycles, null_valid_hi, SKIP ? 0 : 2);
        end
        n_vec++;
        if (err_at_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL null_err: got %0d expected 0", err_at_done);
        end
        null_map[1] = 1'b0;
        null_map[2] = 1'b0;
`ifdef RM_NULL_SKIP_EN
        for (int i = 0; i < 3; i++) null_map[i] = 1'b1;
        build_expect(1, 0, 2);
        run_op(1, 0, 2);
        n_vec++;
        if (err_at_done !== 1'b1 || n_out !== 0) begin
            n_err++;
            $display("[TB] FAIL all_null: got err %0d outs %0d expected 1 0", err_at_done, n_out);
        end
        for (int i = 0; i < 3; i++) null_map[i] = 1'b0;
`endif
    endtask

    task automatic test_stall();
        stall_at = 2;
        build_expect(4, 0, 8);
        run_op(4, 0, 8);
        stall_at = -1;
        n_vec++;
        if (stall_cnt !== 3 || stall_bad_valid !== 0 || stall_bad_rd !== 0) begin
            n_err++;
            $display("[TB] FAIL stall: got cycles %0d lowvalid %0d reads %0d expected 3 0 0",
                     stall_cnt, stall_bad_valid, stall_bad_rd);
        end
    endtask

    task automatic test_config_err();
        build_expect(4, 12, 5);
        run_op(4, 12, 5);
        n_vec++;
        if (done_cyc !== 1 || err_at_done !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cfg_ko: got done %0d err %0d expected 1 1", done_cyc, err_at_done);
        end
        build_expect(0, 0, 3);
        run_op(0, 0, 3);
        n_vec++;
        if (done_cyc !== 1 || err_at_done !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cfg_k0: got done %0d err %0d expected 1 1", done_cyc, err_at_done);
        end
        build_expect(4, 0, 3);
        run_op(4, 0, 3);
        n_vec++;
        if (err_at_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL err_clear: got %0d expected 0", err_at_done);
        end
    endtask

    task automatic test_reset_mid();
        abort_wr = 6;
        build_expect(4, 0, 4);
        run_op(4, 0, 4);
        abort_wr = -1;
        #1;
        n_vec++;
        if ({readRAM1, readRAM2, readRAM3, wr_en, wr_addr, rd_en, rd_addr,
             out_valid, out_last, busy, done, err} !== '0) begin
            n_err++;
            $display("[TB] FAIL mid_reset: got nonzero outputs expected all zero");
        end
        @(negedge clk);
        rst = 1'b1;
        build_expect(4, 5, 7);
        run_op(4, 5, 7);
        n_vec++;
        if (err_at_done !== 1'b0 || last_idx !== 6) begin
            n_err++;
            $display("[TB] FAIL after_reset: got err %0d last %0d expected 0 6", err_at_done, last_idx);
        end
    endtask

    initial begin
        start = 1'b0; src_valid = 1'b0; null_flag = 1'b0; out_ready = 1'b1;
        K_PI = '0; Ko = '0; E = '0;
        src_mode = 0; stall_at = -1; abort_wr = -1;
        for (int i = 0; i < 64; i++) null_map[i] = 1'b0;
        test_reset();
        test_full_pass();
        test_wrap();
        test_src_gaps();
        test_null();
        test_stall();
        test_config_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rm_buff_sequencer.md
Name: rm_buff_sequencer

Overview:
- Top-level sequencer for the rate-matching circular buffer.
- On `start`, it schedules the three sub-block interleaver RAM drains into the buffer:
  - systematic to addresses 0..K_PI-1;
  - parity1 to the even slots above K_PI;
  - parity2 to the odd slots above K_PI.
- It then runs bit selection: it reads E non-null entries starting at Ko, wrapping modulo Ncb=3*K_PI, and streams them out with a valid/ready handshake.
- It replaces ad-hoc done flags with a single FSM and a start/done contract for the upstream scheduler.

Parameters:
- AW, 13, buffer address width.
- KW, 12, width of K_PI.
- EW, 16, width of E and of the output counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; configuration inputs are sampled on this cycle when idle.
- K_PI  in  KW  sub-block interleaver output length.
- Ko  in  AW  selection start offset k0.
- E  in  EW  number of output bits.
- src_valid  in  1  interleaver RAM data valid this cycle.
- readRAM1  out  1  drain sub-block 1 (systematic).
- readRAM2  out  1  drain sub-block 2 (parity1).
- readRAM3  out  1  drain sub-block 3 (parity2).
- wr_en  out  1  buffer write strobe.
- wr_addr  out  AW  buffer write address.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  AW  buffer read address.
- null_flag  in  1  dummy-bit flag of the entry read on the previous cycle.
- out_valid  out  1  selected bit available.
- out_ready  in  1  consumer accepts.
- out_last  out  1  qualifies the E-th accepted bit.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error; cleared by the next accepted start.

Behaviour:
- Reset (async, rst=0): state IDLE.
  - All outputs 0, including wr_addr and rd_addr.
  - All counters 0.
  - Any operation in progress is abandoned with no done pulse.
- IDLE, start=1:
  - Latch K_PI, Ko, E; compute Ncb=3*K_PI in AW+1 bits.
  - Config check: K_PI==0, E==0 or Ko>=Ncb means go to DONE with err=1 and no RAM or buffer activity.
  - Otherwise go to WR1. start is ignored outside IDLE.
- WR1 / WR2 / WR3:
  - readRAMn is high for the whole state.
  - On each cycle with src_valid=1: wr_en=1 and the index i increments. Address per state:
    - WR1: wr_addr=i.
    - WR2: wr_addr=K_PI+2i.
    - WR3: wr_addr=K_PI+2i+1.
  - After i reaches K_PI-1 with src_valid: i clears and the FSM advances (WR1 to WR2, WR2 to WR3, WR3 to SEL). readRAMn drops in the same cycle.
  - Total writes equal 3*K_PI exactly.
- SEL:
  - addr starts at Ko; read latency is 1 cycle; at most one read in flight.
  - A read is issued (rd_en=1, rd_addr=addr) when no output is held, or the held output is being accepted this cycle, and fewer than E bits have been emitted or are pending.
  - addr_next = (addr+1==Ncb) ? 0 : addr+1.
  - Returned entry with null_flag=1: discarded, out_valid stays 0, null_run increments.
  - Returned entry with null_flag=0: out_valid=1 and is held until out_ready; null_run clears.
  - out_last=1 with the E-th output.
  - On the E-th handshake, go to DONE.
  - If null_run reaches Ncb (buffer all dummy), go to DONE with err=1.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Simultaneous out_valid&&out_ready and a new issue in the same cycle is legal: full throughput is 1 bit/cycle.
- Wrap: when Ko=Ncb-1, the second read address is 0.
- E may exceed Ncb; addressing wraps repeatedly.

Optional Feature:
- Macro RM_NULL_SKIP_EN.
- When defined: null entries are skipped as above, and the null_run guard is active.
- When undefined: null_flag is ignored, every read entry is emitted, and SEL takes exactly E reads. The null_run logic is not compiled and err is set only by the config check.

Test Plan:
1. K_PI=4, Ko=0, E=12, src_valid=1, out_ready=1, no nulls:
   - wr_addr sequence 0,1,2,3 / 4,6,8,10 / 5,7,9,11;
   - rd_addr 0..11;
   - done pulses one cycle after out_last.
2. K_PI=4, Ko=10, E=5:
   - rd_addr 10,11,0,1,2;
   - out_last on 5th output.
3. src_valid toggling 1,0,1,0 in WR2: wr_addr holds during gaps and wr_en=0 in gap cycles; still 4 writes per phase.
4. RM_NULL_SKIP_EN, K_PI=4, Ko=0, E=4, null_flag=1 for addresses 1 and 2:
   - outputs come from addresses 0,3,4,5;
   - out_valid is low in the two null cycles.
5. out_ready held low for 3 cycles mid-SEL: out_valid stays high with data stable, no extra rd_en, no bit lost or duplicated.
6. Config check and reset:
   - start with Ko=12, K_PI=4: done next cycle, err=1, no wr_en or rd_en.
   - rst asserted mid-WR2: all outputs 0 immediately.
   - A following start runs cleanly with err cleared.
